// File: rtl/tournament_predictor_nway.sv
// N-wide gshare/simple tournament direction predictor. Predictions are combinational, with zero latency, from the registered BHR and tables.
// There is no backpressure: fetch_stall only freezes the BHR, resolves are always accepted, and table updates become visible one edge later.
module tournament_predictor_nway #(
  parameter int N         = 2,
  parameter int R         = 2,
  parameter int HIST_BITS = 4,
  parameter int CTR_BITS  = 2,
  parameter int META_BITS = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N-1:0]                  fetch_valid,
  input  logic [N-1:0]                  fetch_btb_hit,
  input  logic [N-1:0][31:0]            fetch_pc,
  input  logic                          fetch_stall,
  output logic [N-1:0]                  predict_taken,
  output logic [N-1:0]                  slot_live,
  output logic [N-1:0][3*HIST_BITS+1:0] pred_packet,
  input  logic [R-1:0]                  resolve_valid,
  input  logic [R-1:0][3*HIST_BITS+1:0] resolve_packet,
  input  logic [R-1:0]                  resolve_taken,
  input  logic [R-1:0]                  resolve_mispred
);

  localparam int DEPTH = 2**HIST_BITS;
  localparam logic [CTR_BITS-1:0]  CTR_WEAK  = CTR_BITS'(2**(CTR_BITS-1) - 1);
  localparam logic [META_BITS-1:0] META_WEAK = META_BITS'(2**(META_BITS-1) - 1);

  logic [HIST_BITS-1:0]                 bhr, bhr_nxt, hist_end;
  logic [DEPTH-1:0][CTR_BITS-1:0]       gshare_pht, gshare_nxt;
  logic [DEPTH-1:0][CTR_BITS-1:0]       simple_pht, simple_nxt;
  logic [DEPTH-1:0][META_BITS-1:0]      meta_pht, meta_nxt;

  // Only the index bits of the PC feed the tables.
  logic unused_pc_bits;
  assign unused_pc_bits = ^fetch_pc;

  function automatic logic [CTR_BITS-1:0] ctr_step(input logic [CTR_BITS-1:0] v, input logic up);
    if (up) return (&v) ? v : v + CTR_BITS'(1);
    return (|v) ? v - CTR_BITS'(1) : v;
  endfunction

  function automatic logic [META_BITS-1:0] meta_step(input logic [META_BITS-1:0] v, input logic up);
    if (up) return (&v) ? v : v + META_BITS'(1);
    return (|v) ? v - META_BITS'(1) : v;
  endfunction

  // Walk the bundle oldest to youngest, threading each live branch's own prediction into younger slots' history.
  always_comb begin : predict
    logic [HIST_BITS-1:0] h, sidx, gidx;
    logic gp, sp, live, pt, taken_seen;
    h             = bhr;
    sidx          = '0;
    gidx          = '0;
    gp            = 1'b0;
    sp            = 1'b0;
    live          = 1'b0;
    pt            = 1'b0;
    taken_seen    = 1'b0;
    predict_taken = '0;
    slot_live     = '0;
    pred_packet   = '0;
    for (int i = 0; i < N; i++) begin
      sidx = fetch_pc[i][HIST_BITS+1:2];
      gidx = sidx ^ h;
      gp   = gshare_pht[gidx][CTR_BITS-1];
      sp   = simple_pht[sidx][CTR_BITS-1];
      live = fetch_valid[i] & ~taken_seen;
      pt   = live & fetch_btb_hit[i] & (meta_pht[sidx][META_BITS-1] ? gp : sp);
      slot_live[i]     = live;
      predict_taken[i] = pt;
      pred_packet[i]   = {h, gidx, sidx, gp, sp};
      if (live & fetch_btb_hit[i]) h = (h << 1) | HIST_BITS'(pt);
      taken_seen = taken_seen | pt;
    end
    hist_end = h;
  end

  // Ports are applied in order so that same-entry collisions saturate step by step.
  always_comb begin : train
    logic [HIST_BITS-1:0] gidx, sidx;
    logic gp, sp, t;
    gshare_nxt = gshare_pht;
    simple_nxt = simple_pht;
    meta_nxt   = meta_pht;
    gidx       = '0;
    sidx       = '0;
    gp         = 1'b0;
    sp         = 1'b0;
    t          = 1'b0;
    for (int r = 0; r < R; r++) begin
      if (resolve_valid[r]) begin
        gidx = resolve_packet[r][2*HIST_BITS+1 -: HIST_BITS];
        sidx = resolve_packet[r][HIST_BITS+1 -: HIST_BITS];
        gp   = resolve_packet[r][1];
        sp   = resolve_packet[r][0];
        t    = resolve_taken[r];
        gshare_nxt[gidx] = ctr_step(gshare_nxt[gidx], t);
        simple_nxt[sidx] = ctr_step(simple_nxt[sidx], t);
        if (gp != sp) meta_nxt[sidx] = meta_step(meta_nxt[sidx], gp == t);
      end
    end
  end

  // Descending scan leaves the oldest mispredicting port in control of recovery.
  always_comb begin : bhr_sel
    bhr_nxt = fetch_stall ? bhr : hist_end;
    for (int r = R-1; r >= 0; r--) begin
      if (resolve_valid[r] & resolve_mispred[r])
        bhr_nxt = (resolve_packet[r][3*HIST_BITS+1 -: HIST_BITS] << 1) | HIST_BITS'(resolve_taken[r]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bhr        <= '0;
      gshare_pht <= {DEPTH{CTR_WEAK}};
      simple_pht <= {DEPTH{CTR_WEAK}};
      meta_pht   <= {DEPTH{META_WEAK}};
    end else begin
      bhr        <= bhr_nxt;
      gshare_pht <= gshare_nxt;
      simple_pht <= simple_nxt;
      meta_pht   <= meta_nxt;
    end
  end

endmodule

// File: tb/tb_tournament_predictor_nway.sv
// Bench for tournament_predictor_nway: directed scenarios and randomized traffic checked against an arithmetic reference model.
module tb_tournament_predictor_nway;

  logic             clock = 1'b0;
  logic             reset;
  logic [1:0]       fetch_valid, fetch_btb_hit;
  logic [1:0][31:0] fetch_pc;
  logic             fetch_stall;
  logic [1:0]       predict_taken, slot_live;
  logic [1:0][13:0] pred_packet;
  logic [1:0]       resolve_valid, resolve_taken, resolve_mispred;
  logic [1:0][13:0] resolve_packet;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: plain integer counters and history
  int m_gsh[16], m_smp[16], m_mta[16];
  int m_bhr, exp_hn;
  logic [1:0]       exp_pt, exp_live;
  logic [1:0][13:0] exp_pkt;

  tournament_predictor_nway dut (
    .clock(clock), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_btb_hit(fetch_btb_hit), .fetch_pc(fetch_pc),
    .fetch_stall(fetch_stall),
    .predict_taken(predict_taken), .slot_live(slot_live), .pred_packet(pred_packet),
    .resolve_valid(resolve_valid), .resolve_packet(resolve_packet),
    .resolve_taken(resolve_taken), .resolve_mispred(resolve_mispred)
  );

  always #5 clock = ~clock;

  function automatic void model_reset();
    for (int k = 0; k < 16; k++) begin
      m_gsh[k] = 1; m_smp[k] = 1; m_mta[k] = 1;
    end
    m_bhr = 0;
  endfunction

  function automatic int sat(input int v, input bit up);
    if (up) return (v >= 3) ? 3 : v + 1;
    return (v <= 0) ? 0 : v - 1;
  endfunction

  function automatic void model_predict();
    int h;
    bit seen;
    h = m_bhr;
    seen = 0;
    for (int i = 0; i < 2; i++) begin
      int s, g;
      bit gp, sp, live, pt;
      s    = int'(fetch_pc[i] >> 2) % 16;
      g    = s ^ h;
      gp   = m_gsh[g] >= 2;
      sp   = m_smp[s] >= 2;
      live = fetch_valid[i] && !seen;
      pt   = live && fetch_btb_hit[i] && ((m_mta[s] >= 2) ? gp : sp);
      exp_live[i] = live;
      exp_pt[i]   = pt;
      exp_pkt[i]  = 14'(h * 1024 + g * 64 + s * 4 + int'(gp) * 2 + int'(sp));
      if (live && fetch_btb_hit[i]) h = (h * 2 + int'(pt)) % 16;
      if (pt) seen = 1;
    end
    exp_hn = h;
  endfunction

  function automatic void model_edge();
    bit recovered;
    if (reset == 1'b0) begin
      model_reset();
      return;
    end
    model_predict();
    for (int r = 0; r < 2; r++) begin
      if (resolve_valid[r]) begin
        int g, s;
        bit gp, sp, t;
        g  = int'(resolve_packet[r]) / 64 % 16;
        s  = int'(resolve_packet[r]) / 4 % 16;
        gp = resolve_packet[r][1];
        sp = resolve_packet[r][0];
        t  = resolve_taken[r];
        m_gsh[g] = sat(m_gsh[g], t);
        m_smp[s] = sat(m_smp[s], t);
        if (gp == t && sp != t) m_mta[s] = sat(m_mta[s], 1);
        if (sp == t && gp != t) m_mta[s] = sat(m_mta[s], 0);
      end
    end
    recovered = 0;
    for (int r = 0; r < 2; r++) begin
      if (!recovered && resolve_valid[r] && resolve_mispred[r]) begin
        m_bhr = ((int'(resolve_packet[r]) / 1024) * 2 + int'(resolve_taken[r])) % 16;
        recovered = 1;
      end
    end
    if (!recovered && !fetch_stall) m_bhr = exp_hn;
  endfunction

  task automatic cycle();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_resolve();
    resolve_valid = '0; resolve_mispred = '0; resolve_taken = '0; resolve_packet = '0;
  endtask

  task automatic set_fetch(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
    fetch_valid = v; fetch_btb_hit = 2'b11; fetch_pc[0] = pc0; fetch_pc[1] = pc1;
  endtask

  // Loads an arbitrary BHR through a mispredict recovery on port 0.
  task automatic force_bhr(input int v);
    clear_resolve();
    fetch_valid = '0;
    resolve_valid = 2'b01; resolve_mispred = 2'b01;
    resolve_taken = {1'b0, 1'(v % 2)};
    resolve_packet[0] = {4'(v / 2), 4'd15, 4'd15, 1'b0, 1'b0};
    cycle();
    clear_resolve();
  endtask

  task automatic test_reset();
    clear_resolve();
    fetch_stall = 1'b0;
    set_fetch(2'b11, 32'h40, 32'h44);
    #1;
    n_cmp++;
    if (predict_taken !== 2'b00) begin n_err++; $display("FAIL reset_held_pt: got %b expected 00", predict_taken); end
    @(posedge clock); #1;
    reset = 1'b1;
    #2;
    n_cmp++;
    if ({predict_taken, slot_live} !== 4'b0011) begin n_err++; $display("FAIL reset_release_pt_live: got %b expected 0011", {predict_taken, slot_live}); end
    n_cmp++;
    if (pred_packet !== {14'd68, 14'd0}) begin n_err++; $display("FAIL reset_release_pkt: got %h expected %h", pred_packet, {14'd68, 14'd0}); end
    cycle(); #2;
    n_cmp++;
    if (pred_packet[0][13:10] !== 4'b0000) begin n_err++; $display("FAIL reset_first_bhr: got %b expected 0000", pred_packet[0][13:10]); end
    model_predict();
    n_cmp++;
    if ({predict_taken, slot_live, pred_packet} !== {exp_pt, exp_live, exp_pkt}) begin
      n_err++; $display("FAIL reset_model: got %h expected %h", {predict_taken, slot_live, pred_packet}, {exp_pt, exp_live, exp_pkt});
    end
  endtask

  task automatic test_train();
    set_fetch(2'b11, 32'h40, 32'h44);
    resolve_valid = 2'b01; resolve_taken = 2'b01; resolve_packet[0] = '0;
    #2;
    n_cmp++;
    if (predict_taken !== 2'b00) begin n_err++; $display("FAIL train_no_bypass: got %b expected 00", predict_taken); end
    cycle();
    fetch_stall = 1'b1;
    #2;
    n_cmp++;
    if ({predict_taken, pred_packet[0]} !== {2'b01, 14'd3}) begin n_err++; $display("FAIL train_mid: got %h expected %h", {predict_taken, pred_packet[0]}, {2'b01, 14'd3}); end
    cycle();
    clear_resolve();
    fetch_stall = 1'b0;
    #2;
    n_cmp++;
    if ({predict_taken, slot_live, pred_packet[0]} !== {4'b0101, 14'd3}) begin
      n_err++; $display("FAIL train_predict: got %h expected %h", {predict_taken, slot_live, pred_packet[0]}, {4'b0101, 14'd3});
    end
    model_predict();
    n_cmp++;
    if ({predict_taken, slot_live, pred_packet} !== {exp_pt, exp_live, exp_pkt}) begin
      n_err++; $display("FAIL train_model: got %h expected %h", {predict_taken, slot_live, pred_packet}, {exp_pt, exp_live, exp_pkt});
    end
    cycle();
  endtask

  task automatic test_bundle_hist();
    force_bhr(3);
    set_fetch(2'b11, 32'h48, 32'h4C);
    #2;
    n_cmp++;
    if ({predict_taken, pred_packet[1][13:10]} !== {2'b00, 4'b0110}) begin
      n_err++; $display("FAIL hist_slot1_state: got %b expected 000110", {predict_taken, pred_packet[1][13:10]});
    end
    cycle(); #2;
    n_cmp++;
    if (pred_packet[0][13:10] !== 4'b1100) begin n_err++; $display("FAIL hist_next_bhr_nt: got %b expected 1100", pred_packet[0][13:10]); end
    force_bhr(3);
    set_fetch(2'b11, 32'h40, 32'h44);
    #2;
    n_cmp++;
    if ({predict_taken, slot_live} !== 4'b0101) begin n_err++; $display("FAIL hist_truncate: got %b expected 0101", {predict_taken, slot_live}); end
    model_predict();
    n_cmp++;
    if ({predict_taken, slot_live, pred_packet} !== {exp_pt, exp_live, exp_pkt}) begin
      n_err++; $display("FAIL hist_model: got %h expected %h", {predict_taken, slot_live, pred_packet}, {exp_pt, exp_live, exp_pkt});
    end
    cycle(); #2;
    n_cmp++;
    if (pred_packet[0][13:10] !== 4'b0111) begin n_err++; $display("FAIL hist_next_bhr_t: got %b expected 0111", pred_packet[0][13:10]); end
  endtask

  task automatic test_mispred_priority();
    force_bhr(3);
    set_fetch(2'b11, 32'h48, 32'h4C);
    fetch_stall = 1'b1;
    resolve_valid = 2'b10; resolve_mispred = 2'b10; resolve_taken = 2'b10;
    resolve_packet[1] = {4'b0101, 4'd10, 4'd10, 1'b0, 1'b0};
    cycle();
    clear_resolve();
    #2;
    n_cmp++;
    if (pred_packet[0][13:10] !== 4'b1011) begin n_err++; $display("FAIL mispred_port1: got %b expected 1011", pred_packet[0][13:10]); end
    force_bhr(3);
    set_fetch(2'b11, 32'h48, 32'h4C);
    resolve_valid = 2'b11; resolve_mispred = 2'b11; resolve_taken = 2'b10;
    resolve_packet[0] = {4'b0010, 4'd10, 4'd10, 1'b0, 1'b0};
    resolve_packet[1] = {4'b0101, 4'd10, 4'd10, 1'b0, 1'b0};
    cycle();
    resolve_valid = 2'b00;
    #2;
    n_cmp++;
    if (pred_packet[0][13:10] !== 4'b0100) begin n_err++; $display("FAIL mispred_port0_wins: got %b expected 0100", pred_packet[0][13:10]); end
    cycle(); #2;
    n_cmp++;
    if (pred_packet[0][13:10] !== 4'b0100) begin n_err++; $display("FAIL mispred_without_valid: got %b expected 0100", pred_packet[0][13:10]); end
    model_predict();
    n_cmp++;
    if ({predict_taken, slot_live, pred_packet} !== {exp_pt, exp_live, exp_pkt}) begin
      n_err++; $display("FAIL mispred_model: got %h expected %h", {predict_taken, slot_live, pred_packet}, {exp_pt, exp_live, exp_pkt});
    end
    clear_resolve();
    fetch_stall = 1'b0;
  endtask

  task automatic test_collision();
    logic [1:0] taken_seq [4] = '{2'b11, 2'b11, 2'b00, 2'b01};
    logic [1:0] valid_seq [4] = '{2'b11, 2'b11, 2'b01, 2'b11};
    set_fetch(2'b01, 32'h4C, 32'h50);
    fetch_stall = 1'b1;
    resolve_packet[0] = {4'd0, 4'd3, 4'd3, 1'b1, 1'b1};
    resolve_packet[1] = {4'd0, 4'd3, 4'd3, 1'b1, 1'b1};
    // Counter path 01 -> 11 -> 11 -> 10 -> (11, 10)
    for (int k = 0; k < 4; k++) begin
      resolve_valid = valid_seq[k];
      resolve_taken = taken_seq[k];
      #2;
      model_predict();
      n_cmp++;
      if ({predict_taken, slot_live, pred_packet} !== {exp_pt, exp_live, exp_pkt}) begin
        n_err++; $display("FAIL collision_step%0d: got %h expected %h", k, {predict_taken, slot_live, pred_packet}, {exp_pt, exp_live, exp_pkt});
      end
      cycle();
    end
    resolve_valid = 2'b00;
    #2;
    n_cmp++;
    if (predict_taken !== 2'b01) begin n_err++; $display("FAIL collision_final_10: got %b expected 01", predict_taken); end
    resolve_valid = 2'b01; resolve_taken = 2'b00;
    cycle();
    resolve_valid = 2'b00;
    #2;
    n_cmp++;
    if (predict_taken !== 2'b00) begin n_err++; $display("FAIL collision_then_01: got %b expected 00", predict_taken); end
    clear_resolve();
    fetch_stall = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      fetch_valid   = 2'($urandom);
      fetch_btb_hit = 2'($urandom);
      fetch_pc[0]   = $urandom;
      fetch_pc[1]   = $urandom;
      fetch_stall   = ($urandom_range(0, 3) == 0);
      for (int r = 0; r < 2; r++) begin
        resolve_valid[r]   = ($urandom_range(0, 2) == 0);
        resolve_mispred[r] = ($urandom_range(0, 3) == 0);
        resolve_taken[r]   = 1'($urandom);
        resolve_packet[r]  = 14'($urandom);
      end
      #2;
      model_predict();
      n_cmp++;
      if ({predict_taken, slot_live, pred_packet} !== {exp_pt, exp_live, exp_pkt}) begin
        n_err++; $display("FAIL random_%0d: got %h expected %h", n, {predict_taken, slot_live, pred_packet}, {exp_pt, exp_live, exp_pkt});
      end
      cycle();
    end
    clear_resolve();
    fetch_stall = 1'b0;
  endtask

  task automatic test_async_reset();
    set_fetch(2'b11, 32'h40, 32'h44);
    resolve_valid = 2'b11; resolve_taken = 2'b11;
    resolve_packet[0] = {4'd0, 4'd0, 4'd0, 1'b1, 1'b1};
    resolve_packet[1] = {4'd0, 4'd0, 4'd0, 1'b1, 1'b1};
    cycle();
    cycle();
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({predict_taken, pred_packet[0][13:10]} !== 6'b000000) begin
      n_err++; $display("FAIL async_reset_now: got %b expected 000000", {predict_taken, pred_packet[0][13:10]});
    end
    clear_resolve();
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({predict_taken, slot_live} !== 4'b0011) begin n_err++; $display("FAIL async_reset_weak: got %b expected 0011", {predict_taken, slot_live}); end
    cycle(); #2;
    model_predict();
    n_cmp++;
    if ({predict_taken, slot_live, pred_packet} !== {exp_pt, exp_live, exp_pkt} || pred_packet[0][13:10] !== 4'b0000) begin
      n_err++; $display("FAIL async_reset_after: got %h expected %h", {predict_taken, slot_live, pred_packet}, {exp_pt, exp_live, exp_pkt});
    end
  endtask

  initial begin
    reset = 1'b0;
    fetch_valid = '0; fetch_btb_hit = '0; fetch_pc = '0; fetch_stall = 1'b0;
    resolve_valid = '0; resolve_mispred = '0; resolve_taken = '0; resolve_packet = '0;
    model_reset();
    #12;
    test_reset();
    test_train();
    test_bundle_hist();
    test_mispred_priority();
    test_collision();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tournament_predictor_nway.md
Name: tournament_predictor_nway

Overview:
- Parametrised N-wide tournament direction predictor. Components: gshare PHT, PC-indexed (simple) PHT, and a meta chooser PHT.
- Sits beside fetch/BTB. Predicts every BTB-hit slot in a fetch bundle in the same cycle.
- Outcome-aware speculative history: each slot's history includes the predicted outcomes of older branches in the bundle. The bundle is truncated after the first predicted-taken branch.
- Accepts R resolutions per cycle, applies same-index collisions in order, and performs history recovery on mispredict.

Parameters:
- N, 2, fetch slots per cycle
- R, 2, resolve ports per cycle; port 0 is oldest
- HIST_BITS, 4, BHR width and PHT index width; PHT depth = 2**HIST_BITS
- CTR_BITS, 2, gshare/simple saturating counter width
- META_BITS, 2, chooser counter width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- fetch_valid  in  N  slot holds a real instruction
- fetch_btb_hit  in  N  slot is a branch per BTB
- fetch_pc  in  N x 32  slot PC (ADDR)
- fetch_stall  in  1  bundle not consumed; BHR holds
- predict_taken  out  N  per-slot taken prediction
- slot_live  out  N  slot survives truncation
- pred_packet  out  N x (3*HIST_BITS+2)  per slot: {bhr_state, gshare_idx, simple_idx, gshare_pred, simple_pred}
- resolve_valid  in  R  resolving branch on port r
- resolve_packet  in  R x (3*HIST_BITS+2)  packet captured at fetch
- resolve_taken  in  R  actual direction (not XORed)
- resolve_mispred  in  R  direction mispredicted

Behaviour:
- Reset (reset=0, async):
  - bhr=0.
  - gshare/simple counters = 2**(CTR_BITS-1)-1 (weak not-taken).
  - meta counters = 2**(META_BITS-1)-1 (weak simple).
  - Outputs are combinational from this state, so predict_taken=0 for all slots.
- Indexing:
  - simple_idx = pc[HIST_BITS+1:2].
  - gshare_idx = simple_idx ^ bhr_state of that slot.
- Counter sense: a counter predicts taken iff its MSB=1. Meta MSB=1 selects gshare, else simple.
- Bundle history, combinational, zero latency:
  - h0 = bhr.
  - For slot i: bhr_state = h_i.
  - If slot i is a live BTB hit: h_{i+1} = (h_i<<1)|predict_taken[i], truncated to HIST_BITS. Otherwise h_{i+1} = h_i.
- Truncation:
  - slot_live[i] = fetch_valid[i] and no older live slot has predict_taken=1.
  - predict_taken[i] = slot_live & btb_hit & chosen prediction.
  - Dead slots output predict_taken=0, and their packets do not affect the BHR.
- BHR update at each rising edge, in priority order:
  1. Any resolve r with resolve_valid & resolve_mispred: bhr <= (packet.bhr_state<<1)|resolve_taken for the lowest-numbered such r. This wins over fetch and over stall.
  2. Else if !fetch_stall: bhr <= h_N.
  3. Else hold.
- PHT update, at the edge after resolve_valid:
  - gshare[gshare_idx] and simple[simple_idx] saturate toward resolve_taken (+1 if taken, -1 otherwise), clamped at 0 and 2**CTR_BITS-1.
  - meta[simple_idx] changes only when exactly one of gshare_pred/simple_pred equals resolve_taken: +1 if gshare was correct, -1 if simple was correct, saturating.
  - Multiple ports hitting the same entry in one cycle are applied sequentially, port 0 then port 1, with saturation after each step.
- No bypass: predictions in the same cycle as a resolve read pre-update tables. The update is visible from the next cycle.
- resolve_mispred without resolve_valid is ignored.
- Mid-operation reset clears everything immediately and asynchronously. The first edge after release behaves as a post-reset cycle.
- All BHR arithmetic is truncated to HIST_BITS. Shifts drop the MSB.

Test Plan:
- Reset release, pc0=0x40, pc1=0x44, both BTB hits -> predict_taken=00, slot_live=11, bhr_state=0000 for both, simple_idx=0 and 1; after one edge with no stall, bhr=0000.
- Resolve port0 taken twice, simple_idx=0, gshare_idx=0, preds 0/0 -> simple[0] goes 01→10→11, meta[0] stays 01; next fetch of pc 0x40 with bhr 0 -> predict_taken[0]=1, slot_live=01.
- bhr=0011, both slots BTB hits predicting NT -> slot1 bhr_state=0110, next bhr=1100. With slot0 predicted taken instead -> slot_live=01, next bhr=0111.
- Same cycle: fetch would set bhr=1100 and fetch_stall=1; port1 mispred with bhr_state=0101, taken=1 -> next bhr=1011. Add port0 mispred with bhr_state=0010, taken=0 -> port0 wins, bhr=0100.
- Both ports resolve simple_idx 3 with counter at 11, both taken -> stays 11. At 10, port0 taken and port1 not-taken -> 11 then 10, final 10.
- Assert reset low mid-cycle after training -> bhr=0 and predict_taken=0 before the next edge; after release, counters read weak not-taken again.
